// File: rtl/pixel_mem_pkg.sv
// Shared types and defaults for the double-buffered pixel memory.
// Provides the controller state encoding and default geometry.
package pixel_mem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SWAP_WAIT
  } state_t;

endpackage

// File: rtl/pixel_bank_ram.sv
// One pixel bank: single write port, A-side and B-side registered reads.
// Ports: we/waddr/wdata write; a_rd/a_addr->q_a, b_rd/b_addr->q_b.
module pixel_bank_ram
  import pixel_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter bit RDW_NEW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              a_rd,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] q_a,
  input  logic              b_rd,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] q_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // q registers hold when their read enable is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      if (a_rd) begin
        if (RDW_NEW && we && waddr == a_addr) q_a <= wdata;
        else q_a <= mem[a_addr];
      end
      if (b_rd) q_b <= mem[b_addr];
    end
  end

endmodule

// File: rtl/pixel_pingpong_mem.sv
// Ping-pong pixel store: port A owns the back bank, port B the front.
// Ports: A r/w, B read, swap_req/clear_req control, front_sel/busy/swap_done.
module pixel_pingpong_mem
  import pixel_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter bit RDW_NEW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              wren_a,
  input  logic              rden_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic              rden_b,
  output logic [DATA_W-1:0] q_b,
  input  logic              swap_req,
  input  logic              clear_req,
  output logic              front_sel,
  output logic              busy,
  output logic              swap_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              pend;
  logic              a_sel;
  logic              b_sel;

  logic              clr;
  logic              back;
  logic              we_any;
  logic              rd_a;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] qa0, qa1, qb0, qb1;

  assign clr    = (state == CLEAR);
  assign back   = ~front_sel;
  assign we_any = clr | wren_a;
  assign rd_a   = rden_a & ~clr;
  assign waddr  = clr ? cnt : address_a;
  assign wdata  = clr ? '0 : data_a;

  pixel_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RDW_NEW(RDW_NEW)
  ) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (we_any & ~back),
    .waddr (waddr),
    .wdata (wdata),
    .a_rd  (rd_a & ~back),
    .a_addr(address_a),
    .q_a   (qa0),
    .b_rd  (rden_b & ~front_sel),
    .b_addr(address_b),
    .q_b   (qb0)
  );

  pixel_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RDW_NEW(RDW_NEW)
  ) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (we_any & back),
    .waddr (waddr),
    .wdata (wdata),
    .a_rd  (rd_a & back),
    .a_addr(address_a),
    .q_a   (qa1),
    .b_rd  (rden_b & front_sel),
    .b_addr(address_b),
    .q_b   (qb1)
  );

  // remember which bank served the last read so q holds across swaps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sel <= 1'b0;
      b_sel <= 1'b0;
    end else begin
      if (rd_a) a_sel <= back;
      if (rden_b) b_sel <= front_sel;
    end
  end

  assign q_a = a_sel ? qa1 : qa0;
  assign q_b = b_sel ? qb1 : qb0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= 1'b0;
      front_sel <= 1'b0;
      busy      <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      unique case (state)
        IDLE: begin
          priority case (1'b1)
            clear_req: begin
              state <= CLEAR;
              busy  <= 1'b1;
              cnt   <= '0;
              pend  <= swap_req;
            end
            (swap_req && !wren_a): begin
              front_sel <= ~front_sel;
              swap_done <= 1'b1;
            end
            swap_req: state <= SWAP_WAIT;
            default: ;
          endcase
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (swap_req) pend <= 1'b1;
          if (cnt == LAST) begin
            busy  <= 1'b0;
            pend  <= 1'b0;
            state <= (pend || swap_req) ? SWAP_WAIT : IDLE;
          end
        end
        SWAP_WAIT: begin
          // only a write-free edge is a safe swap point
          if (!wren_a) begin
            front_sel <= ~front_sel;
            swap_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_pingpong_mem.sv
// Bench for pixel_pingpong_mem: scoreboarded reads on both ports,
// swap/clear sequencing, RDW behaviour on two builds.
module tb_pixel_pingpong_mem;

  localparam int DW    = 16;
  localparam int AW    = 9;
  localparam int DEPTH = 2**AW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] address_a;
  logic [DW-1:0] data_a;
  logic          wren_a;
  logic          rden_a;
  logic [AW-1:0] address_b;
  logic          rden_b;
  logic          swap_req;
  logic          clear_req;

  logic [DW-1:0] q_a, q_b, q_a_o, q_b_o;
  logic front_sel, busy, swap_done;
  logic front_sel_o, busy_o, swap_done_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [DW-1:0] mem_m [2][DEPTH];
  logic          front_m;
  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];

  pixel_pingpong_mem #(.DATA_W(DW), .ADDR_W(AW), .RDW_NEW(1'b1)) dut (
    .clk(clk), .rst(rst),
    .address_a(address_a), .data_a(data_a),
    .wren_a(wren_a), .rden_a(rden_a), .q_a(q_a),
    .address_b(address_b), .rden_b(rden_b), .q_b(q_b),
    .swap_req(swap_req), .clear_req(clear_req),
    .front_sel(front_sel), .busy(busy), .swap_done(swap_done)
  );

  pixel_pingpong_mem #(.DATA_W(DW), .ADDR_W(AW), .RDW_NEW(1'b0)) dut_old (
    .clk(clk), .rst(rst),
    .address_a(address_a), .data_a(data_a),
    .wren_a(wren_a), .rden_a(rden_a), .q_a(q_a_o),
    .address_b(address_b), .rden_b(rden_b), .q_b(q_b_o),
    .swap_req(swap_req), .clear_req(clear_req),
    .front_sel(front_sel_o), .busy(busy_o), .swap_done(swap_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
    address_a = a;
    data_a = d;
    wren_a = 1'b1;
    mem_m[!front_m][a] = d;
    tick();
    wren_a = 1'b0;
  endtask

  task automatic read_a(input logic [AW-1:0] a);
    address_a = a;
    rden_a = 1'b1;
    exp_a.push_back(mem_m[!front_m][a]);
    tick();
    rden_a = 1'b0;
  endtask

  task automatic read_b(input logic [AW-1:0] a);
    address_b = a;
    rden_b = 1'b1;
    exp_b.push_back(mem_m[front_m][a]);
    tick();
    rden_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt += 5;
    if (q_a !== '0 || q_a_o !== '0)
      $display("FAIL reset_q_a: got %h/%h expected 0", q_a, q_a_o);
    else pass_cnt++;
    if (q_b !== '0) $display("FAIL reset_q_b: got %h expected 0", q_b);
    else pass_cnt++;
    if (front_sel !== 1'b0)
      $display("FAIL reset_front: got %b expected 0", front_sel);
    else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else pass_cnt++;
    if (swap_done !== 1'b0)
      $display("FAIL reset_done: got %b expected 0", swap_done);
    else pass_cnt++;
    rst = 1'b0;
    front_m = 1'b0;
    tick();
    total_cnt++;
    if (front_sel !== 1'b0 || busy !== 1'b0)
      $display("FAIL post_reset: got %b%b expected 00", front_sel, busy);
    else pass_cnt++;
  endtask

  task automatic test_swap();
    logic [DW-1:0] e;
    write_a(3, 16'hAAAA);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    front_m = 1'b1;
    total_cnt += 2;
    if (front_sel !== 1'b1)
      $display("FAIL swap_front: got %b expected 1", front_sel);
    else pass_cnt++;
    if (swap_done !== 1'b1)
      $display("FAIL swap_done_hi: got %b expected 1", swap_done);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (swap_done !== 1'b0)
      $display("FAIL swap_done_lo: got %b expected 0", swap_done);
    else pass_cnt++;
    read_b(3);
    e = exp_b.pop_front();
    total_cnt++;
    if (q_b !== e) $display("FAIL swap_read_b: got %h expected %h", q_b, e);
    else pass_cnt++;
  endtask

  task automatic test_swap_wait();
    logic [DW-1:0] e;
    for (int i = 0; i < 4; i++) begin
      address_a = AW'(10 + i);
      data_a = DW'(16'h1000 + i);
      wren_a = 1'b1;
      swap_req = (i == 0);
      mem_m[!front_m][10 + i] = DW'(16'h1000 + i);
      tick();
      swap_req = 1'b0;
      total_cnt++;
      if (front_sel !== 1'b1 || swap_done !== 1'b0)
        $display("FAIL wait_hold%0d: got %b%b expected 10",
                 i, front_sel, swap_done);
      else pass_cnt++;
    end
    wren_a = 1'b0;
    tick();
    front_m = 1'b0;
    total_cnt++;
    if (front_sel !== 1'b0 || swap_done !== 1'b1)
      $display("FAIL wait_swap: got %b%b expected 01", front_sel, swap_done);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      read_b(AW'(10 + i));
      e = exp_b.pop_front();
      total_cnt++;
      if (q_b !== e)
        $display("FAIL wait_read_b%0d: got %h expected %h", i, q_b, e);
      else pass_cnt++;
    end
    write_a(20, 16'h5678);
    address_a = 20;
    data_a = 16'h1234;
    wren_a = 1'b1;
    rden_a = 1'b1;
    mem_m[!front_m][20] = 16'h1234;
    tick();
    wren_a = 1'b0;
    rden_a = 1'b0;
    total_cnt += 2;
    if (q_a !== 16'h1234)
      $display("FAIL rdw_new: got %h expected 1234", q_a);
    else pass_cnt++;
    if (q_a_o !== 16'h5678)
      $display("FAIL rdw_old: got %h expected 5678", q_a_o);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    logic [DW-1:0] e;
    int n;
    for (int i = 0; i < DEPTH; i++) write_a(AW'(i), 16'hFFFF);
    read_a(0);
    e = exp_a.pop_front();
    total_cnt++;
    if (q_a !== e || q_a_o !== e)
      $display("FAIL fill_read: got %h/%h expected %h", q_a, q_a_o, e);
    else pass_cnt++;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[!front_m][i] = '0;
    n = 0;
    wren_a = 1'b1;
    rden_a = 1'b1;
    data_a = 16'hBEEF;
    while (busy === 1'b1 && n < 2000) begin
      address_a = n[0] ? AW'(DEPTH - 1) : AW'(0);
      n++;
      tick();
    end
    wren_a = 1'b0;
    rden_a = 1'b0;
    total_cnt += 2;
    if (n !== DEPTH) $display("FAIL clear_busy_len: got %0d expected %0d", n, DEPTH);
    else pass_cnt++;
    if (q_a !== 16'hFFFF)
      $display("FAIL clear_q_a_hold: got %h expected ffff", q_a);
    else pass_cnt++;
    read_a(0);
    read_a(AW'(DEPTH - 1));
    write_a(7, 16'h0777);
    read_a(7);
    for (int i = 0; i < 3; i++) begin
      e = exp_a.pop_front();
      total_cnt++;
      // only the last pending read is visible on q_a now
      if (i == 2) begin
        if (q_a !== e)
          $display("FAIL clear_after_write: got %h expected %h", q_a, e);
        else pass_cnt++;
      end else begin
        if (e !== '0)
          $display("FAIL clear_model%0d: got %h expected 0", i, e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_clear_read();
    logic [DW-1:0] e;
    read_a(0);
    e = exp_a.pop_front();
    total_cnt++;
    if (q_a !== e) $display("FAIL cleared_addr0: got %h expected %h", q_a, e);
    else pass_cnt++;
    read_a(AW'(DEPTH - 1));
    e = exp_a.pop_front();
    total_cnt++;
    if (q_a !== e) $display("FAIL cleared_last: got %h expected %h", q_a, e);
    else pass_cnt++;
  endtask

  task automatic test_clear_swap();
    logic [DW-1:0] e;
    int n;
    clear_req = 1'b1;
    swap_req = 1'b1;
    tick();
    clear_req = 1'b0;
    swap_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[!front_m][i] = '0;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    total_cnt += 2;
    if (n !== DEPTH) $display("FAIL cs_busy_len: got %0d expected %0d", n, DEPTH);
    else pass_cnt++;
    if (front_sel !== 1'b0)
      $display("FAIL cs_early_swap: got %b expected 0", front_sel);
    else pass_cnt++;
    read_b(10);
    front_m = 1'b1;
    e = exp_b.pop_front();
    total_cnt += 2;
    if (front_sel !== 1'b1 || swap_done !== 1'b1)
      $display("FAIL cs_swap: got %b%b expected 11", front_sel, swap_done);
    else pass_cnt++;
    if (q_b !== e) $display("FAIL cs_old_front: got %h expected %h", q_b, e);
    else pass_cnt++;
    read_b(3);
    read_b(AW'(DEPTH - 1));
    e = exp_b.pop_front();
    e = exp_b.pop_front();
    total_cnt++;
    if (q_b !== e) $display("FAIL cs_new_front: got %h expected %h", q_b, e);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt += 2;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy);
    else pass_cnt++;
    if (front_sel !== 1'b0)
      $display("FAIL rst_front: got %b expected 0", front_sel);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    front_m = 1'b0;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || swap_done !== 1'b0)
      $display("FAIL rst_after: got %b%b expected 00", busy, swap_done);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    address_a = '0;
    data_a = '0;
    wren_a = 1'b0;
    rden_a = 1'b0;
    address_b = '0;
    rden_b = 1'b0;
    swap_req = 1'b0;
    clear_req = 1'b0;
    front_m = 1'b0;
    test_reset();
    test_swap();
    test_swap_wait();
    test_clear();
    test_clear_read();
    test_clear_swap();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
